// File: rtl/gpio_intr_ctrl_if.sv
// ---------------------------------------------------------------------------
// gpio_intr_ctrl_if
// Bundles the interrupt-source inputs and the CPU-facing interrupt outputs of
// gpio_intr_ctrl.
//   master : the side that owns the sources and the CPU handshake
//            (drives intr_src, mask, irq_ack, overrun_clr; reads irq, irq_id,
//            pending, overrun)
//   slave  : the interrupt controller itself
// Signals:
//   intr_src    [NUM_SRC] source pulses, active high, >=1 cycle wide
//   mask        [NUM_SRC] 1 = source may raise irq
//   irq_ack               1-cycle ack for the current irq_id
//   overrun_clr           1-cycle pulse clearing all overrun bits
//   irq                   level interrupt to the CPU
//   irq_id      [ID_W]    index of the serviced source, valid while irq=1
//   pending     [NUM_SRC] latched, unserviced events
//   overrun     [NUM_SRC] sticky, event arrived while already pending
// ---------------------------------------------------------------------------
interface gpio_intr_ctrl_if #(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = 2
);
  logic [NUM_SRC-1:0] intr_src;
  logic [NUM_SRC-1:0] mask;
  logic               irq_ack;
  logic               overrun_clr;
  logic               irq;
  logic [ID_W-1:0]    irq_id;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] overrun;

  modport master (
    output intr_src, mask, irq_ack, overrun_clr,
    input  irq, irq_id, pending, overrun
  );

  modport slave (
    input  intr_src, mask, irq_ack, overrun_clr,
    output irq, irq_id, pending, overrun
  );
endinterface

// File: rtl/gpio_intr_ctrl.sv
// ---------------------------------------------------------------------------
// gpio_intr_ctrl
// Interrupt controller for the periodic GPIO interrupt sources. Rising edges
// on intr_src latch one pending bit per source; enabled pending sources are
// served one at a time by fixed priority (lowest index first) through a
// level irq plus irq_id, which the CPU retires with irq_ack.
//
// Parameters:
//   NUM_SRC  number of interrupt sources (1..16)
//   ID_W     width of irq_id, 2**ID_W >= NUM_SRC
// Ports:
//   clk_25m_in  in  system clock, 25 MHz
//   hard_rst_n  in  asynchronous active-low reset
//   bus         gpio_intr_ctrl_if.slave (intr_src, mask, irq_ack, overrun_clr
//               in; irq, irq_id, pending, overrun out)
// Build option:
//   INTR_SYNC_EN  when defined, a 2-flop synchronizer is placed on each
//                 intr_src bit (sources from another clock domain); this adds
//                 2 cycles of edge-to-pending latency. When undefined,
//                 intr_src must be synchronous to clk_25m_in.
// ---------------------------------------------------------------------------
module gpio_intr_ctrl #(
  parameter int NUM_SRC = 4,
  parameter int ID_W    = 2
) (
  input  logic               clk_25m_in,
  input  logic               hard_rst_n,
  gpio_intr_ctrl_if.slave    bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ASSERT  = 2'd1,
    HOLDOFF = 2'd2
  } state_t;

  state_t             state;
  logic               irq_q;
  logic [ID_W-1:0]    irq_id_q;
  logic [NUM_SRC-1:0] pending_q;
  logic [NUM_SRC-1:0] overrun_q;
  logic [NUM_SRC-1:0] src_s;
  logic [NUM_SRC-1:0] src_d;
  logic [NUM_SRC-1:0] rise;
  logic [NUM_SRC-1:0] clr_vec;
  logic [NUM_SRC-1:0] pending_nxt;
  logic [NUM_SRC-1:0] overrun_set;
  logic [NUM_SRC-1:0] overrun_nxt;
  logic               ack_fire;

  // Lowest set index wins; scanning downward lets the lowest hit overwrite.
  function automatic logic [ID_W-1:0] prio_enc(input logic [NUM_SRC-1:0] v);
    logic [ID_W-1:0] id;
    id = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (v[i]) id = ID_W'(i);
    end
    return id;
  endfunction

  function automatic logic [NUM_SRC-1:0] id_onehot(input logic [ID_W-1:0] id);
    logic [NUM_SRC-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      oh[i] = (ID_W'(i) == id);
    end
    return oh;
  endfunction

`ifdef INTR_SYNC_EN
  logic [NUM_SRC-1:0] sync_p0;
  logic [NUM_SRC-1:0] sync_p1;

  // Two-flop synchronizer stage
  always_ff @(posedge clk_25m_in or negedge hard_rst_n) begin
    if (!hard_rst_n) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= bus.intr_src;
      sync_p1 <= sync_p0;
    end
  end

  assign src_s = sync_p1;
`else
  assign src_s = bus.intr_src;
`endif

  // Edge detect: a source held high yields exactly one rise.
  assign rise = src_s & ~src_d;

  // Ack only counts while an irq is actually being presented.
  assign ack_fire = (state == ASSERT) && bus.irq_ack;
  assign clr_vec  = ack_fire ? id_onehot(irq_id_q) : '0;

  // A rise coinciding with the clear re-arms the bit as a fresh event, so it
  // is excluded from overrun detection.
  assign pending_nxt = (pending_q & ~clr_vec) | rise;
  assign overrun_set = rise & pending_q & ~clr_vec;
  // A same-cycle set beats overrun_clr.
  assign overrun_nxt = (bus.overrun_clr ? '0 : overrun_q) | overrun_set;

  // Edge-detect / pending / overrun stage
  always_ff @(posedge clk_25m_in or negedge hard_rst_n) begin
    if (!hard_rst_n) begin
      src_d     <= '0;
      pending_q <= '0;
      overrun_q <= '0;
    end else begin
      src_d     <= src_s;
      pending_q <= pending_nxt;
      overrun_q <= overrun_nxt;
    end
  end

  // Service FSM stage: decides from registered pending, so bits latched on
  // this edge are seen one cycle later.
  always_ff @(posedge clk_25m_in or negedge hard_rst_n) begin
    if (!hard_rst_n) begin
      state    <= IDLE;
      irq_q    <= 1'b0;
      irq_id_q <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (|(pending_q & bus.mask)) begin
            irq_id_q <= prio_enc(pending_q & bus.mask);
            irq_q    <= 1'b1;
            state    <= ASSERT;
          end
        end
        ASSERT: begin
          // irq_id stays frozen and mask changes are ignored until the ack.
          if (bus.irq_ack) begin
            irq_q <= 1'b0;
            state <= HOLDOFF;
          end
        end
        HOLDOFF: begin
          // One guaranteed low cycle so a level-sensitive CPU sees the drop.
          state <= IDLE;
        end
        default: begin
          irq_q <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.irq     = irq_q;
  assign bus.irq_id  = irq_id_q;
  assign bus.pending = pending_q;
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_gpio_intr_ctrl.sv
// ---------------------------------------------------------------------------
// tb_gpio_intr_ctrl
// Directed self-checking bench for gpio_intr_ctrl (NUM_SRC=4, ID_W=2).
// Inputs change 1 ns after the rising edge and outputs are checked there too,
// well away from the next active edge. SL is the extra synchronizer latency
// so the same sequences cover builds with and without INTR_SYNC_EN.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_gpio_intr_ctrl;

`ifdef INTR_SYNC_EN
  localparam int SL = 2;
`else
  localparam int SL = 0;
`endif

  logic clk_25m_in;
  logic hard_rst_n;
  int   checks;
  int   errors;

  gpio_intr_ctrl_if #(.NUM_SRC(4), .ID_W(2)) bus ();

  gpio_intr_ctrl #(.NUM_SRC(4), .ID_W(2)) dut (
    .clk_25m_in (clk_25m_in),
    .hard_rst_n (hard_rst_n),
    .bus        (bus)
  );

  initial clk_25m_in = 1'b0;
  always #20 clk_25m_in = ~clk_25m_in;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk_25m_in);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // One-cycle ack, then confirm the two guaranteed low cycles.
  task automatic ack_and_holdoff(input string tag, input logic [3:0] pend_exp);
    bus.irq_ack = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
    chk({tag, "_irq_lo_a"}, {31'd0, bus.irq}, 32'd0);
    chk({tag, "_pend_ack"}, {28'd0, bus.pending}, {28'd0, pend_exp});
    tick();
    chk({tag, "_irq_lo_a1"}, {31'd0, bus.irq}, 32'd0);
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    hard_rst_n      = 1'b0;
    bus.intr_src    = 4'h0;
    bus.mask        = 4'hF;
    bus.irq_ack     = 1'b0;
    bus.overrun_clr = 1'b0;

    // Reset state
    ticks(3);
    chk("rst_irq",     {31'd0, bus.irq},     32'd0);
    chk("rst_id",      {30'd0, bus.irq_id},  32'd0);
    chk("rst_pending", {28'd0, bus.pending}, 32'd0);
    chk("rst_overrun", {28'd0, bus.overrun}, 32'd0);
    hard_rst_n = 1'b1;
    ticks(2);

    // Test 1: single pulse on src 2
    bus.intr_src = 4'b0100;
    tick();                                   // E0
    bus.intr_src = 4'b0000;
    ticks(SL);
    chk("t1_pend",    {28'd0, bus.pending}, 32'h4);
    chk("t1_irq_e0",  {31'd0, bus.irq},     32'd0);
    tick();                                   // E1 (+SL)
    chk("t1_irq_e1",  {31'd0, bus.irq},     32'd1);
    chk("t1_id",      {30'd0, bus.irq_id},  32'd2);
    ack_and_holdoff("t1", 4'b0000);
    tick();
    chk("t1_irq_idle", {31'd0, bus.irq},    32'd0);

    // Test 2: simultaneous pulses on 1 and 3, priority order
    bus.intr_src = 4'b1010;
    tick();
    bus.intr_src = 4'b0000;
    ticks(SL);
    chk("t2_pend",  {28'd0, bus.pending}, 32'hA);
    tick();
    chk("t2_irq1",  {31'd0, bus.irq},     32'd1);
    chk("t2_id1",   {30'd0, bus.irq_id},  32'd1);
    ack_and_holdoff("t2a", 4'b1000);
    tick();                                   // A+2: earliest re-assert
    chk("t2_irq3",  {31'd0, bus.irq},     32'd1);
    chk("t2_id3",   {30'd0, bus.irq_id},  32'd3);
    ack_and_holdoff("t2b", 4'b0000);

    // Test 3: masked source latches but does not interrupt
    bus.mask     = 4'b1110;
    bus.intr_src = 4'b0001;
    tick();
    bus.intr_src = 4'b0000;
    ticks(SL);
    chk("t3_pend", {28'd0, bus.pending}, 32'h1);
    ticks(2);
    chk("t3_irq_masked", {31'd0, bus.irq}, 32'd0);
    // Ack in IDLE must be ignored
    bus.irq_ack = 1'b1;
    tick();
    bus.irq_ack = 1'b0;
    chk("t3_ack_ignored", {28'd0, bus.pending}, 32'h1);
    bus.mask = 4'hF;
    tick();
    chk("t3_irq_unmask", {31'd0, bus.irq},    32'd1);
    chk("t3_id",         {30'd0, bus.irq_id}, 32'd0);
    ack_and_holdoff("t3", 4'b0000);

    // Test 4: overrun on src 2, clear, then ack coincident with a new rise
    bus.intr_src = 4'b0100;
    tick();
    bus.intr_src = 4'b0000;
    tick();
    bus.intr_src = 4'b0100;
    tick();
    bus.intr_src = 4'b0000;
    ticks(SL);
    chk("t4_overrun", {28'd0, bus.overrun}, 32'h4);
    chk("t4_irq",     {31'd0, bus.irq},     32'd1);
    chk("t4_id",      {30'd0, bus.irq_id},  32'd2);
    bus.overrun_clr = 1'b1;
    tick();
    bus.overrun_clr = 1'b0;
    chk("t4_ovr_clr", {28'd0, bus.overrun}, 32'h0);
    bus.intr_src = 4'b0100;
    ticks(SL);
    bus.irq_ack = 1'b1;
    tick();                                   // rise and ack on the same edge
    bus.irq_ack  = 1'b0;
    bus.intr_src = 4'b0000;
    chk("t4_pend_keep", {28'd0, bus.pending}, 32'h4);
    chk("t4_ovr_keep",  {28'd0, bus.overrun}, 32'h0);
    chk("t4_irq_lo",    {31'd0, bus.irq},     32'd0);
    ticks(2);
    chk("t4_irq_again", {31'd0, bus.irq},     32'd1);
    chk("t4_id_again",  {30'd0, bus.irq_id},  32'd2);
    ack_and_holdoff("t4", 4'b0000);

    // Test 5: long level on src 0 gives one event
    bus.intr_src = 4'b0001;
    ticks(100);
    chk("t5_pend",    {28'd0, bus.pending}, 32'h1);
    chk("t5_overrun", {28'd0, bus.overrun}, 32'h0);
    chk("t5_irq",     {31'd0, bus.irq},     32'd1);
    chk("t5_id",      {30'd0, bus.irq_id},  32'd0);
    ack_and_holdoff("t5", 4'b0000);
    bus.intr_src = 4'b0000;
    ticks(3);
    chk("t5_no_second", {31'd0, bus.irq},   32'd0);

    // Mid-operation reset while irq is high
    bus.intr_src = 4'b1000;
    tick();
    bus.intr_src = 4'b0000;
    ticks(SL + 1);
    chk("t5_irq3", {31'd0, bus.irq},    32'd1);
    chk("t5_id3",  {30'd0, bus.irq_id}, 32'd3);
    #5 hard_rst_n = 1'b0;
    #1;
    chk("t5_rst_irq",  {31'd0, bus.irq},     32'd0);
    chk("t5_rst_id",   {30'd0, bus.irq_id},  32'd0);
    chk("t5_rst_pend", {28'd0, bus.pending}, 32'h0);
    tick();
    hard_rst_n = 1'b1;
    ticks(3);
    chk("t5_post_rst_irq", {31'd0, bus.irq}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
